// File: rtl/uart_rx_msg_pkg.sv
// Shared constants, bit-timing helper and FSM state types for the UART message receiver.
package uart_pkg;

    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_DASH = 8'h2D;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(50000000, 115200);

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_WAIT
    } bit_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_DASH1,
        P_PAY,
        P_TERM
    } par_state_t;

endpackage

// File: rtl/uart_rx_msg_if.sv
// Four-phase message handshake between the receiver (master) and the bot logic (slave).
interface uart_rx_msg_if #(
    parameter int unsigned MAX_LEN = 8
);
    logic [8*MAX_LEN-1:0] msg_payload;
    logic [3:0]           msg_len;
    logic                 msg_req;
    logic                 msg_ack;

    modport master (output msg_payload, output msg_len, output msg_req, input msg_ack);
    modport slave  (input msg_payload, input msg_len, input msg_req, output msg_ack);
endinterface

// File: rtl/uart_rx_msg_bit.sv
// 8N1 UART byte receiver: rx synchroniser, bit FSM and baud counter.
module uart_rx_bit
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err
);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

    logic          rx_m, rx_s;
    bit_state_t    state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick_half, tick_full;
    logic          cnt_run, cnt_clr, shift_en, byte_ok, byte_bad;

    assign tick_half = (cnt == CW'(HALF - 1));
    assign tick_full = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            state <= B_IDLE;
        end else begin
            rx_m  <= rx;
            rx_s  <= rx_m;
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            B_IDLE:  if (!rx_s) state_nx = B_START;
            B_START: if (tick_half) state_nx = rx_s ? B_IDLE : B_DATA;
            B_DATA:  if (tick_full && bit_idx == 3'd7) state_nx = B_STOP;
            B_STOP:  if (tick_full) state_nx = rx_s ? B_IDLE : B_WAIT;
            B_WAIT:  if (rx_s) state_nx = B_IDLE;
            default: state_nx = B_IDLE;
        endcase
    end

    // Counter restarts on every state change so each phase times from its own entry.
    always_comb begin
        cnt_run  = (state == B_START) || (state == B_DATA) || (state == B_STOP);
        cnt_clr  = (state != state_nx);
        shift_en = (state == B_DATA) && tick_full;
        byte_ok  = (state == B_STOP) && tick_full && rx_s;
        byte_bad = (state == B_STOP) && tick_full && !rx_s;
        if (shift_en) cnt_clr = 1'b1;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            cnt           <= (!cnt_run || cnt_clr) ? '0 : cnt + 1'b1;
            bit_idx       <= (state != B_DATA) ? '0 : (shift_en ? bit_idx + 1'b1 : bit_idx);
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
            if (byte_ok) rx_byte <= shreg;
            rx_byte_valid <= byte_ok;
            frame_err     <= byte_bad;
        end
    end

endmodule

// File: rtl/uart_rx_msg.sv
// Frames #-<payload>-# messages from the UART byte stream and hands them over via req/ack.
// Optional UART_RX_ERRCNT_EN adds a saturating err_count port.
module uart_rx_msg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned BAUD    = 115200,
    parameter int unsigned MAX_LEN = 8
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [7:0]           rx_byte,
    output logic                 rx_byte_valid,
    uart_rx_msg_if.master        msg,
    output logic                 frame_err,
    output logic                 msg_err
`ifdef UART_RX_ERRCNT_EN
    ,
    output logic [7:0]           err_count
`endif
);
    localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);

    par_state_t           state, state_nx;
    logic [8*MAX_LEN-1:0] pay_buf;
    logic [3:0]           pay_len;
    logic                 is_hash, is_dash, room, busy;
    logic                 buf_clr, buf_app, deliver, err_c;

    uart_rx_bit #(.CLKS_PER_BIT(CPB)) u_bit (
        .clk_50M       (clk_50M),
        .rst_n         (rst_n),
        .rx            (rx),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .frame_err     (frame_err)
    );

    assign is_hash = (rx_byte == CH_HASH);
    assign is_dash = (rx_byte == CH_DASH);
    assign room    = (pay_len < 4'(MAX_LEN));
    assign busy    = msg.msg_req || msg.msg_ack;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) state <= P_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (rx_byte_valid) begin
            case (state)
                P_IDLE:  if (is_hash) state_nx = P_DASH1;
                P_DASH1: state_nx = is_dash ? P_PAY : (is_hash ? P_DASH1 : P_IDLE);
                P_PAY: begin
                    if (is_dash)                            state_nx = P_TERM;
                    else if (is_hash)                       state_nx = P_DASH1;
                    else if (is_printable(rx_byte) && room) state_nx = P_PAY;
                    else                                    state_nx = P_IDLE;
                end
                P_TERM:  state_nx = P_IDLE;
                default: state_nx = P_IDLE;
            endcase
        end
    end

    // Every entry into P_DASH1 begins a fresh message, so the buffer is cleared there.
    always_comb begin
        buf_clr = rx_byte_valid && (state_nx == P_DASH1);
        buf_app = 1'b0;
        deliver = 1'b0;
        err_c   = 1'b0;
        if (rx_byte_valid) begin
            case (state)
                P_DASH1: err_c = !is_dash && !is_hash;
                P_PAY: begin
                    buf_app = !is_dash && !is_hash && is_printable(rx_byte) && room;
                    err_c   = !is_dash && !buf_app;
                end
                P_TERM: begin
                    deliver = is_hash && (pay_len != 4'd0) && !busy;
                    err_c   = !deliver;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            pay_buf         <= '0;
            pay_len         <= '0;
            msg.msg_payload <= '0;
            msg.msg_len     <= '0;
            msg.msg_req     <= 1'b0;
            msg_err         <= 1'b0;
        end else begin
            if (buf_clr) begin
                pay_buf <= '0;
                pay_len <= '0;
            end else if (buf_app) begin
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    if (pay_len == 4'(i)) pay_buf[i*8 +: 8] <= rx_byte;
                end
                pay_len <= pay_len + 1'b1;
            end
            if (deliver) begin
                msg.msg_payload <= pay_buf;
                msg.msg_len     <= pay_len;
                msg.msg_req     <= 1'b1;
            end else if (msg.msg_ack) begin
                msg.msg_req     <= 1'b0;
            end
            msg_err <= err_c;
        end
    end

`ifdef UART_RX_ERRCNT_EN
    logic [8:0] err_sum;
    assign err_sum = {1'b0, err_count} + {8'd0, frame_err} + {8'd0, msg_err};

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) err_count <= '0;
        else        err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
`endif

endmodule

// File: doc/uart_rx_msg.md
# uart_rx_msg

Receive path from the control host (CH) to the AstroTinker Bot (AB). The block deserialises 8N1 UART frames at 115200 baud on the 50 MHz system clock. It assembles framed ASCII messages of the form `#-<payload>-#` and presents each complete payload to the bot logic over a four-phase req/ack handshake. It is the counterpart of the bot's message transmitter and uses the same framing characters and handshake style.

## Interface
- `CLK_HZ`, 50000000, system clock frequency.
- `BAUD`, 115200, line rate.
- `MAX_LEN`, 8, maximum payload characters; the payload bus is `8*MAX_LEN` bits.

Ports:
- `clk_50M  in  1`  system clock; the only clock.
- `rst_n  in  1`  reset, asynchronous, active-low.
- `rx  in  1`  serial line from CH; idles high.
- `rx_byte  out  8`  last good received byte.
- `rx_byte_valid  out  1`  one-cycle pulse when `rx_byte` updates.
- `msg_payload  out  8*MAX_LEN`  payload; first character in [7:0]; unused bytes are 0.
- `msg_len  out  4`  payload length, 1..MAX_LEN.
- `msg_req  out  1`  message available (four-phase).
- `msg_ack  in  1`  consumer acknowledge.
- `frame_err  out  1`  one-cycle pulse on a bad stop bit.
- `msg_err  out  1`  one-cycle pulse on malformed, overlong, empty or dropped message.
- `err_count  out  8`  present only with `UART_RX_ERRCNT_EN`; see Configuration.

## Operation
- Reset: all outputs are 0 and both FSMs are idle. The `rx` synchroniser flops reset to 1.
- `rx` passes through a 2-FF synchroniser.
- Bit timing: `CLKS_PER_BIT = CLK_HZ/BAUD` using integer division, giving 434.

Bit FSM states and transitions:
- B_IDLE: on a synchronised falling edge, go to B_START.
- B_START: at count `CLKS_PER_BIT/2` (217), sample the line.
  - If high, it is a false start: return to B_IDLE silently.
  - Otherwise go to B_DATA.
- B_DATA: sample every 434 clocks, LSB first, 8 bits.
- B_STOP: sample once.
  - If 1, latch the byte and pulse `rx_byte_valid`.
  - If 0, pulse `frame_err`, discard the byte, and go to B_WAIT.
- B_WAIT: stay until the line is high, then return to B_IDLE.

Parser FSM (advances only on `rx_byte_valid`):
- P_IDLE: on `#`, go to P_DASH1. Any other byte is ignored.
- P_DASH1: on `-`, go to P_PAY.
  - On `#`, stay in P_DASH1 (resync).
  - Otherwise pulse `msg_err` and go to P_IDLE.
- P_PAY: a printable character other than `-` or `#` is appended.
  - On `-`, go to P_TERM.
  - On `#`, pulse `msg_err` and go to P_DASH1 (resync).
  - On the (MAX_LEN+1)th character, pulse `msg_err` and go to P_IDLE.
- P_TERM: on `#`, the message is complete.
  - If length is 0 (`#--#`), pulse `msg_err`.
  - Otherwise deliver. Either way, go to P_IDLE.
  - Any other byte: pulse `msg_err` and go to P_IDLE.

Delivery handshake:
- On delivery, load `msg_payload` and `msg_len`, then raise `msg_req`.
- Outputs stay stable while `msg_req` is high.
- When `msg_ack` rises, drop `msg_req`.
- A new message may be raised only after `msg_ack` is seen low again.
- A message that completes while `msg_req` or `msg_ack` is high is dropped, and `msg_err` pulses. Byte reception and parsing continue regardless.
- A reset mid-message discards the partial message and any pending request.

## Timing
- `rx_byte_valid` follows the line start edge by 2 clocks (synchroniser) + 217 + 9×434 clocks, ±1 clock.
- `msg_req` rises 1 clock after the `rx_byte_valid` of the terminating `#`.
- `msg_req` falls 1 clock after `msg_ack` is sampled high.
- Back-to-back frames with no idle gap are received without loss. The stop-bit sample point leaves about 217 clocks to detect the next start edge.
- `frame_err` and `msg_err` may pulse in the same cycle; each is independent.

## Configuration
- `UART_RX_ERRCNT_EN` defined:
  - Adds port `err_count`, an 8-bit saturating counter of `frame_err` + `msg_err` events.
  - When both pulse in the same clock, it adds 2 (saturating at 255).
  - It is cleared only by reset.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `uart_pkg` holds:
  - ASCII constants `CH_HASH` (8'h23) and `CH_DASH` (8'h2D).
  - The `CLKS_PER_BIT` computation.
  - The bit FSM and parser FSM state encodings.
- Sub-module `uart_rx_bit` contains the synchroniser, bit FSM and baud counter, and outputs `rx_byte`, `rx_byte_valid` and `frame_err`.
- `uart_rx_msg` instantiates `uart_rx_bit` and contains the parser, the payload buffer, the handshake and the optional counter.

## Test plan
- Send `#-1B-#`, then ack after 10 clocks.
  - `msg_len`=2 and `msg_payload[15:0]`=16'h4231.
  - `msg_req` is high until 1 clock after ack and does not re-rise.
- Send a 0x55 byte with stop bit forced 0.
  - `frame_err` pulses once and `rx_byte_valid` stays 0.
  - A following `#-A-#` is still delivered.
- Send a 100-clock low glitch on `rx`: no `rx_byte_valid` and no errors.
- Send `#-ABCDEFGHI-#` (9 chars): `msg_err` pulses and `msg_req` stays 0.
- Send two messages back-to-back, holding `msg_ack` low: the second causes a `msg_err` pulse and the first payload stays stable.
- Assert `rst_n` low mid-payload, release, then send `#-DN-#`.
  - All outputs are 0 during reset.
  - After release, `msg_payload[15:0]`=16'h4E44 and `msg_len`=2.
  - With `UART_RX_ERRCNT_EN`, `err_count` is 0 after reset.
